compute_sequencer: RTL and testbench

Parametrised successor to the systolic compute controller. It sequences activation streaming from the unified buffer through an MUL_SIZE×MUL_SIZE MAC array over an arbitrary grid of weight tiles (k_tiles along the reduction dimension × n_tiles along the output dimension). It swaps the double-buffered weights with a per-row wavefront overlapped with streaming, so back-to-back tiles have no bubble. It sits between the weight loader (valid/consume handshake), the unified buffer read port and the MAC array/accumulators.

---
 rtl/compute_sequencer_pkg.sv | 25 ++
 rtl/compute_sequencer_wavefront.sv | 53 +++++
 rtl/compute_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_compute_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compute_sequencer_pkg.sv
// Shared definitions for the compute sequencer slice.
// Holds the sequencer state encoding, the default parameter values used by
// the top and the wavefront sub-module, and the helper that derives the
// drain length from the MAC array size.
package tpu_package;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_W,
    STREAM,
    DRAIN
  } seq_state_e;

  localparam int DEF_MUL_SIZE = 32;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DIM_W    = 9;
  localparam int DEF_TILE_W   = 4;

  // The last activation needs 2*MUL_SIZE-1 further cycles to ripple across
  // the array diagonal before every accumulator has seen it.
  function automatic int drainCycles(input int mulSize);
    return 2 * mulSize - 1;
  endfunction

endpackage

// File: rtl/compute_sequencer_wavefront.sv
// weight_wavefront: per-row weight bank swap for the MAC array.
// A fire pulse travels down a MUL_SIZE-deep shift register; each stage
// toggles the bank select of its own row, so row r swaps r cycles after
// row 0. Every bit is independent, so a new fire may enter before the
// previous one has left (tiles shorter than the array).
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   fire_i         one pulse per new weight tile (the consume pulse)
//   flush_i        drop all pending toggles; bank selects hold
//   weight_sel_o   per-row active weight bank
module weight_wavefront
  import tpu_package::*;
#(
  parameter int MUL_SIZE = DEF_MUL_SIZE
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fire_i,
  input  logic                flush_i,
  output logic [MUL_SIZE-1:0] weight_sel_o
);

  logic [MUL_SIZE-1:0] pend_q, pend_d;
  logic [MUL_SIZE-1:0] sel_q, sel_d;

  // The fire enters at stage 0 the cycle after consume; stage r then flips
  // row r on the following edge. The consume leads the first MAC cycle by
  // two, which lands the row-0 swap on that first MAC cycle.
  always_comb begin
    pend_d = '0;
    sel_d  = sel_q;
    if (!flush_i) begin
      pend_d[0] = fire_i;
      for (int r = 1; r < MUL_SIZE; r++) begin
        pend_d[r] = pend_q[r-1];
      end
      sel_d = sel_q ^ pend_q;
    end
  end

  // Shift register and bank-select state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      sel_q  <= '0;
    end else begin
      pend_q <= pend_d;
      sel_q  <= sel_d;
    end
  end

  assign weight_sel_o = sel_q;

endmodule

// File: rtl/compute_sequencer.sv
// compute_sequencer: streams activations from the unified buffer through
// the MAC array over a k_tiles x n_tiles grid of weight tiles, swapping the
// double-buffered weights with a per-row wavefront so consecutive tiles run
// without a bubble.
//   start_i/abort_i             command request / synchronous abort
//   rows_i,k_tiles_i,n_tiles_i  tile geometry (latched at start)
//   ub_base_addr_i, ub_tile_stride_i, accumulate_i  addressing, acc mode
//   weights_valid_i/weights_consume_o  weight loader handshake
//   ub_rd_en_o, ub_rd_addr_o    buffer read port (data one cycle later)
//   load_activations_o, mac_en_o, acc_first_o, weight_sel_o  array control
//   tile_k_o, tile_n_o          indices of the tile being streamed
//   busy_o, done_o              command in flight / completion pulse
module compute_sequencer
  import tpu_package::*;
#(
  parameter int MUL_SIZE = DEF_MUL_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DIM_W    = DEF_DIM_W,
  parameter int TILE_W   = DEF_TILE_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DIM_W-1:0]    rows_i,
  input  logic [TILE_W-1:0]   k_tiles_i,
  input  logic [TILE_W-1:0]   n_tiles_i,
  input  logic [ADDR_W-1:0]   ub_base_addr_i,
  input  logic [ADDR_W-1:0]   ub_tile_stride_i,
  input  logic                accumulate_i,
  input  logic                weights_valid_i,
  output logic                weights_consume_o,
  output logic                ub_rd_en_o,
  output logic [ADDR_W-1:0]   ub_rd_addr_o,
  output logic                load_activations_o,
  output logic                mac_en_o,
  output logic                acc_first_o,
  output logic [MUL_SIZE-1:0] weight_sel_o,
  output logic [TILE_W-1:0]   tile_k_o,
  output logic [TILE_W-1:0]   tile_n_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int DRAIN_LEN = drainCycles(MUL_SIZE);
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 2);
  // MAC stays on for the first DRAIN_LEN drain cycles; one more cycle lets
  // the last registered mac_en_o retire before done_o.
  localparam logic [DRAIN_W-1:0] DRAIN_MAC_END = DRAIN_W'(DRAIN_LEN);
  localparam logic [DRAIN_W-1:0] DRAIN_DONE    = DRAIN_W'(DRAIN_LEN + 1);

  seq_state_e          state_q, state_d;
  logic [DIM_W-1:0]    rows_q, rows_d, rowCnt_q, rowCnt_d;
  logic [TILE_W-1:0]   kTiles_q, kTiles_d, nTiles_q, nTiles_d;
  logic [TILE_W-1:0]   kCnt_q, kCnt_d, nCnt_q, nCnt_d;
  logic [ADDR_W-1:0]   base_q, base_d, stride_q, stride_d;
  logic [ADDR_W-1:0]   tileBase_q, tileBase_d, addr_q, addr_d;
  logic                accum_q, accum_d;
  logic [DRAIN_W-1:0]  drainCnt_q, drainCnt_d;
  logic                macEn_q, accFirst_q;
  logic                rdEn, consume, done;
  logic                lastRow, lastK, lastN;

  assign lastRow = (rowCnt_q == rows_q - DIM_W'(1));
  assign lastK   = (kCnt_q == kTiles_q - TILE_W'(1));
  assign lastN   = (nCnt_q == nTiles_q - TILE_W'(1));

  // Next-state and handshake logic. Loop order is row, then k, then n; the
  // read address is a running adder that restarts from the tile base, which
  // itself steps by the stride per k tile and returns to base per n tile.
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    kTiles_d   = kTiles_q;
    nTiles_d   = nTiles_q;
    base_d     = base_q;
    stride_d   = stride_q;
    accum_d    = accum_q;
    rowCnt_d   = rowCnt_q;
    kCnt_d     = kCnt_q;
    nCnt_d     = nCnt_q;
    tileBase_d = tileBase_q;
    addr_d     = addr_q;
    drainCnt_d = drainCnt_q;
    rdEn       = 1'b0;
    consume    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rows_d     = rows_i;
          kTiles_d   = k_tiles_i;
          nTiles_d   = n_tiles_i;
          base_d     = ub_base_addr_i;
          stride_d   = ub_tile_stride_i;
          accum_d    = accumulate_i;
          rowCnt_d   = '0;
          kCnt_d     = '0;
          nCnt_d     = '0;
          tileBase_d = ub_base_addr_i;
          addr_d     = ub_base_addr_i;
          drainCnt_d = '0;
          if (rows_i == '0 || k_tiles_i == '0 || n_tiles_i == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = WAIT_W;
          end
        end
      end
      WAIT_W: begin
        if (weights_valid_i) begin
          consume = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        rdEn     = 1'b1;
        rowCnt_d = rowCnt_q + DIM_W'(1);
        addr_d   = addr_q + ADDR_W'(1);
        if (lastRow) begin
          rowCnt_d = '0;
          if (lastK) begin
            kCnt_d     = '0;
            tileBase_d = base_q;
            if (!lastN) begin
              nCnt_d = nCnt_q + TILE_W'(1);
            end
          end else begin
            kCnt_d     = kCnt_q + TILE_W'(1);
            tileBase_d = tileBase_q + stride_q;
          end
          addr_d = tileBase_d;
          if (lastK && lastN) begin
            state_d    = DRAIN;
            drainCnt_d = '0;
          end else if (weights_valid_i) begin
            // Next tile already resident: swap without leaving STREAM.
            consume = 1'b1;
          end else begin
            state_d = WAIT_W;
          end
        end
      end
      DRAIN: begin
        drainCnt_d = drainCnt_q + DRAIN_W'(1);
        if (drainCnt_q == DRAIN_DONE) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      rdEn    = 1'b0;
      consume = 1'b0;
      done    = 1'b0;
    end
  end

  // Command state, counters and the one-cycle read-data alignment stage.
  // An abort clears the alignment stage so nothing in flight reaches the array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      kTiles_q   <= '0;
      nTiles_q   <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      accum_q    <= 1'b0;
      rowCnt_q   <= '0;
      kCnt_q     <= '0;
      nCnt_q     <= '0;
      tileBase_q <= '0;
      addr_q     <= '0;
      drainCnt_q <= '0;
      macEn_q    <= 1'b0;
      accFirst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      kTiles_q   <= kTiles_d;
      nTiles_q   <= nTiles_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      accum_q    <= accum_d;
      rowCnt_q   <= rowCnt_d;
      kCnt_q     <= kCnt_d;
      nCnt_q     <= nCnt_d;
      tileBase_q <= tileBase_d;
      addr_q     <= addr_d;
      drainCnt_q <= drainCnt_d;
      macEn_q    <= !abort_i &&
                    (rdEn || (state_q == DRAIN && drainCnt_q < DRAIN_MAC_END));
      accFirst_q <= rdEn && (kCnt_q == '0) && !accum_q;
    end
  end

  weight_wavefront #(
    .MUL_SIZE (MUL_SIZE)
  ) u_wavefront (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fire_i       (consume),
    .flush_i      (abort_i),
    .weight_sel_o (weight_sel_o)
  );

  assign weights_consume_o  = consume;
  assign ub_rd_en_o         = rdEn;
  assign ub_rd_addr_o       = addr_q;
  assign load_activations_o = macEn_q;
  assign mac_en_o           = macEn_q;
  assign acc_first_o        = accFirst_q;
  assign tile_k_o           = kCnt_q;
  assign tile_n_o           = nCnt_q;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = done;

endmodule

// File: tb/tb_compute_sequencer.sv
// Self-checking bench for compute_sequencer (MUL_SIZE=4).
// Each command is described by its configuration and a per-cycle
// weights_valid pattern; a tile-level reference model derives every
// expected per-cycle output from the loop-nest definition, then the run is
// replayed against the DUT.
module tb_compute_sequencer;

  localparam int MUL_SIZE = 4;
  localparam int ADDR_W   = 12;
  localparam int DIM_W    = 9;
  localparam int TILE_W   = 4;
  localparam int MAXC     = 512;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                start_i = 1'b0;
  logic                abort_i = 1'b0;
  logic [DIM_W-1:0]    rows_i = '0;
  logic [TILE_W-1:0]   k_tiles_i = '0;
  logic [TILE_W-1:0]   n_tiles_i = '0;
  logic [ADDR_W-1:0]   ub_base_addr_i = '0;
  logic [ADDR_W-1:0]   ub_tile_stride_i = '0;
  logic                accumulate_i = 1'b0;
  logic                weights_valid_i = 1'b0;
  logic                weights_consume_o;
  logic                ub_rd_en_o;
  logic [ADDR_W-1:0]   ub_rd_addr_o;
  logic                load_activations_o;
  logic                mac_en_o;
  logic                acc_first_o;
  logic [MUL_SIZE-1:0] weight_sel_o;
  logic [TILE_W-1:0]   tile_k_o;
  logic [TILE_W-1:0]   tile_n_o;
  logic                busy_o;
  logic                done_o;

  int compared = 0;
  int mismatched = 0;

  // Reference-model state: per-cycle expectations of the current command
  // and the bank selects carried over between commands.
  logic                validPat [MAXC];
  logic                expRd    [MAXC];
  logic [ADDR_W-1:0]   expAddr  [MAXC];
  logic [TILE_W-1:0]   expK     [MAXC];
  logic [TILE_W-1:0]   expN     [MAXC];
  logic                expCons  [MAXC];
  logic                expMac   [MAXC];
  logic                expAccF  [MAXC];
  logic                expDone  [MAXC];
  logic                expBusy  [MAXC];
  logic [MUL_SIZE-1:0] togAt    [MAXC];
  logic [MUL_SIZE-1:0] modelSel = '0;

  compute_sequencer #(
    .MUL_SIZE (MUL_SIZE),
    .ADDR_W   (ADDR_W),
    .DIM_W    (DIM_W),
    .TILE_W   (TILE_W)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .abort_i            (abort_i),
    .rows_i             (rows_i),
    .k_tiles_i          (k_tiles_i),
    .n_tiles_i          (n_tiles_i),
    .ub_base_addr_i     (ub_base_addr_i),
    .ub_tile_stride_i   (ub_tile_stride_i),
    .accumulate_i       (accumulate_i),
    .weights_valid_i    (weights_valid_i),
    .weights_consume_o  (weights_consume_o),
    .ub_rd_en_o         (ub_rd_en_o),
    .ub_rd_addr_o       (ub_rd_addr_o),
    .load_activations_o (load_activations_o),
    .mac_en_o           (mac_en_o),
    .acc_first_o        (acc_first_o),
    .weight_sel_o       (weight_sel_o),
    .tile_k_o           (tile_k_o),
    .tile_n_o           (tile_n_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Last-resort guard so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setAllValid();
    for (int i = 0; i < MAXC; i++) validPat[i] = 1'b1;
  endtask

  // Builds the expected trace of one command from its loop nest, then drives
  // it cycle by cycle (cycle 0 = start cycle) and checks every output.
  // Entered and left just after a rising edge.
  task automatic applyStimulus(input string name, input int rows, input int kT,
                               input int nT, input int base, input int stride,
                               input int acc, input int abortAt,
                               input int startAgain);
    int slot;
    int t;
    int lastRead;
    int doneC;
    int endC;
    logic [MUL_SIZE-1:0] selRun;

    for (int i = 0; i < MAXC; i++) begin
      expRd[i] = 0; expAddr[i] = '0; expK[i] = '0; expN[i] = '0;
      expCons[i] = 0; expMac[i] = 0; expAccF[i] = 0; expDone[i] = 0;
      expBusy[i] = 0; togAt[i] = '0;
    end
    lastRead = 0;
    slot = 1;
    if (rows != 0 && kT != 0 && nT != 0) begin
      for (int ni = 0; ni < nT; ni++) begin
        for (int ki = 0; ki < kT; ki++) begin
          while (!validPat[slot] && slot < MAXC - 64) slot++;
          expCons[slot] = 1;
          for (int r = 0; r < MUL_SIZE; r++)
            togAt[slot+2+r][r] = ~togAt[slot+2+r][r];
          for (int row = 0; row < rows; row++) begin
            t = slot + 1 + row;
            expRd[t]   = 1;
            expAddr[t] = ADDR_W'(base + ki * stride + row);
            expK[t]    = TILE_W'(ki);
            expN[t]    = TILE_W'(ni);
            expAccF[t+1] = (ki == 0) && (acc == 0);
            lastRead = t;
          end
          slot = slot + rows;
        end
      end
    end
    doneC = lastRead + 2 * MUL_SIZE + 1;
    for (int i = 1; i < MAXC; i++)
      expMac[i] = expRd[i-1] || (i >= lastRead + 2 && i <= lastRead + 2 * MUL_SIZE);
    for (int i = 1; i <= doneC; i++) expBusy[i] = 1;
    expDone[doneC] = 1;
    endC = doneC + 2;
    if (abortAt > 0) begin
      for (int i = abortAt; i < MAXC; i++) begin
        expRd[i] = 0; expCons[i] = 0; expDone[i] = 0;
        if (i > abortAt) begin
          expMac[i] = 0; expBusy[i] = 0; expAccF[i] = 0; togAt[i] = '0;
        end
      end
      endC = abortAt + 3;
    end

    rows_i           = DIM_W'(rows);
    k_tiles_i        = TILE_W'(kT);
    n_tiles_i        = TILE_W'(nT);
    ub_base_addr_i   = ADDR_W'(base);
    ub_tile_stride_i = ADDR_W'(stride);
    accumulate_i     = (acc != 0);
    selRun = modelSel;
    for (int c = 0; c <= endC; c++) begin
      start_i         = (c == 0) || (c == startAgain);
      abort_i         = (c == abortAt);
      weights_valid_i = validPat[c];
      selRun = selRun ^ togAt[c];
      @(negedge clk_i);
      checkOutput($sformatf("%s.rd_en@%0d", name, c), ub_rd_en_o, expRd[c]);
      checkOutput($sformatf("%s.consume@%0d", name, c), weights_consume_o, expCons[c]);
      checkOutput($sformatf("%s.mac_en@%0d", name, c), mac_en_o, expMac[c]);
      checkOutput($sformatf("%s.load_act@%0d", name, c), load_activations_o, expMac[c]);
      checkOutput($sformatf("%s.acc_first@%0d", name, c), acc_first_o, expAccF[c]);
      checkOutput($sformatf("%s.done@%0d", name, c), done_o, expDone[c]);
      checkOutput($sformatf("%s.busy@%0d", name, c), busy_o, expBusy[c]);
      checkOutput($sformatf("%s.weight_sel@%0d", name, c), weight_sel_o, selRun);
      if (expRd[c]) begin
        checkOutput($sformatf("%s.addr@%0d", name, c), ub_rd_addr_o, expAddr[c]);
        checkOutput($sformatf("%s.tile_k@%0d", name, c), tile_k_o, expK[c]);
        checkOutput($sformatf("%s.tile_n@%0d", name, c), tile_n_o, expN[c]);
      end
      @(posedge clk_i);
      #1;
    end
    modelSel = selRun;
    start_i = 1'b0;
    abort_i = 1'b0;
    weights_valid_i = 1'b0;
  endtask

  initial begin
    // Reset state.
    #2;
    checkOutput("reset.busy", busy_o, 1'b0);
    checkOutput("reset.mac_en", mac_en_o, 1'b0);
    checkOutput("reset.rd_en", ub_rd_en_o, 1'b0);
    checkOutput("reset.done", done_o, 1'b0);
    checkOutput("reset.weight_sel", weight_sel_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Two k tiles back to back, weights always resident.
    setAllValid();
    applyStimulus("basic", 8, 2, 1, 'h100, 'h20, 1, -1, -1);

    // Weights missing for cycles 9..12: the second tile slips four cycles.
    setAllValid();
    for (int i = 9; i <= 12; i++) validPat[i] = 1'b0;
    applyStimulus("stall", 8, 2, 1, 'h100, 'h20, 1, -1, -1);

    // Overwrite mode over a 3x2 grid with tiles shorter than the array;
    // a stray start mid-command must be ignored.
    setAllValid();
    applyStimulus("grid", 3, 3, 2, 'h040, 'h10, 0, -1, 5);

    // Address wrap at the top of the buffer.
    setAllValid();
    applyStimulus("wrap", 4, 1, 1, 'hFFE, 1, 1, -1, -1);

    // Abort mid-stream, then the same command restarts from base.
    setAllValid();
    applyStimulus("abort", 8, 2, 1, 'h100, 'h20, 1, 4, -1);
    applyStimulus("restart", 8, 2, 1, 'h100, 'h20, 1, -1, -1);

    // Empty command: drain only.
    setAllValid();
    applyStimulus("zero", 0, 2, 1, 'h100, 'h20, 0, -1, -1);

    // Abort and start together in IDLE: abort wins.
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abortstart.busy0", busy_o, 1'b0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abortstart.busy1", busy_o, 1'b0);
    checkOutput("abortstart.rd_en", ub_rd_en_o, 1'b0);
    @(posedge clk_i);
    #1;

    // Randomised commands with random weight availability.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < MAXC; i++)
        validPat[i] = (i >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      applyStimulus($sformatf("rand%0d", n), int'($urandom_range(1, 6)),
                    int'($urandom_range(1, 3)), int'($urandom_range(1, 2)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 1)), -1, -1);
    end

    // Reset asserted mid-DRAIN of an empty command clears outputs at once.
    rows_i    = '0;
    k_tiles_i = TILE_W'(1);
    n_tiles_i = TILE_W'(1);
    start_i   = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rstdrain.busy_before", busy_o, 1'b1);
    checkOutput("rstdrain.mac_before", mac_en_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rstdrain.busy", busy_o, 1'b0);
    checkOutput("rstdrain.mac_en", mac_en_o, 1'b0);
    checkOutput("rstdrain.done", done_o, 1'b0);
    checkOutput("rstdrain.weight_sel", weight_sel_o, '0);
    checkOutput("rstdrain.rd_en", ub_rd_en_o, 1'b0);
    modelSel = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
